// File: rtl/mat_pkg.sv
// rtl/mat_pkg.sv - shared matrix operand definitions
// Purpose: default geometry of the matrix operand register, reader FSM
//          state encoding and the sweep address mapping.
// Ports:   none (package).
package mat_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int ADDR_WIDTH  = 4;
  localparam int HALF_WIDTH  = ADDR_WIDTH / 2;
  localparam int MATRIX_SIZE = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // idx is {row, col}; the transposed sweep walks columns first, so the
  // register is addressed with the two halves swapped.
  function automatic logic [ADDR_WIDTH-1:0] sweep_addr(input logic [ADDR_WIDTH-1:0] idx,
                                                       input logic                  transpose);
    if (transpose) begin
      return {idx[HALF_WIDTH-1:0], idx[ADDR_WIDTH-1:HALF_WIDTH]};
    end
    return idx;
  endfunction

endpackage

// File: rtl/operand_skid_fifo.sv
// rtl/operand_skid_fifo.sv - two-entry FIFO absorbing read latency and backpressure
// Purpose: holds returned operand words ({last, data}) until the consumer
//          takes them; push and pop in the same cycle are legal even when full.
// Ports:   clk_i/rst_ni   clock, asynchronous active-low reset
//          flush_i        drop all stored entries (wins over push/pop)
//          push_i/push_data_i  write one entry
//          pop_i          remove the head entry
//          head_o         current head entry
//          count_o        number of stored entries (0..2)
module operand_skid_fifo #(
  parameter int WIDTH = 33
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  // When full, a push is only accepted if the head leaves in the same cycle;
  // the write then lands in the slot being vacated.
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/operand_reg_reader.sv
// rtl/operand_reg_reader.sv - streaming read master for the matrix operand register
// Purpose: on start_i sweeps every entry of one operand register (row-major or
//          transposed) and streams the words out with valid/ready and a last flag.
// Ports:   clk_i/rst_ni        clock, asynchronous active-low reset
//          start_i/transpose_i begin a sweep, order selected at start
//          clear_i             synchronous abort and flush
//          addr_Mat_o/write_en_Mat_o/read_data_Mat_i  operand register port
//          data_o/valid_o/ready_i/last_o              output stream
//          busy_o              sweep in progress
//          done_o              one-cycle pulse after the final handshake
module operand_reg_reader #(
  parameter int DATA_WIDTH  = mat_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH  = mat_pkg::ADDR_WIDTH,
  parameter int MATRIX_SIZE = mat_pkg::MATRIX_SIZE,
  parameter int RD_LAT      = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  transpose_i,
  input  logic                  clear_i,
  output logic [ADDR_WIDTH-1:0] addr_Mat_o,
  output logic                  write_en_Mat_o,
  input  logic [DATA_WIDTH-1:0] read_data_Mat_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  import mat_pkg::state_t;
  import mat_pkg::IDLE;
  import mat_pkg::RUN;
  import mat_pkg::sweep_addr;

  // One extra bit so idx can step past the final entry instead of wrapping.
  localparam int IDX_W = ADDR_WIDTH + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MATRIX_SIZE - 1);
  localparam logic [IDX_W-1:0] END_IDX  = IDX_W'(MATRIX_SIZE);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q;
  logic                  transpose_q;
  logic                  prime_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  done_q;

  logic                  start_go;
  logic                  issue;
  logic                  issue_last;
  logic                  pop;
  logic                  last_hs;
  logic                  push;
  logic                  push_last;
  logic                  inflight;
  logic [2:0]            occupancy;
  logic [2:0]            room_limit;
  logic [ADDR_WIDTH-1:0] next_idx;
  logic [1:0]            fifo_count;
  logic [DATA_WIDTH:0]   fifo_head;

  assign start_go   = (state_q == IDLE) && start_i && !clear_i;
  assign pop        = valid_o && ready_i && !clear_i;
  assign last_hs    = pop && fifo_head[DATA_WIDTH];
  assign issue_last = (idx_q == LAST_IDX);
  assign next_idx   = idx_q[ADDR_WIDTH-1:0] + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  // Count stored plus in-flight words; an entry popped this cycle frees a
  // slot immediately, which is what keeps the stream bubble-free.
  assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight};
  assign room_limit = pop ? 3'd3 : 3'd2;

  // The first RUN cycle only presents the start address to the register;
  // reads are issued from the following cycle on.
  assign issue = (state_q == RUN) && !prime_q && !clear_i &&
                 (idx_q < END_IDX) && (occupancy < room_limit);

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_i) state_d = RUN;
        RUN:     if (last_hs) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      transpose_q <= 1'b0;
      prime_q     <= 1'b0;
      addr_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last_hs;
      if (start_go) begin
        idx_q       <= '0;
        transpose_q <= transpose_i;
        prime_q     <= 1'b1;
        addr_q      <= sweep_addr('0, transpose_i);
      end else begin
        prime_q <= 1'b0;
        if (issue) begin
          idx_q <= idx_q + 1'b1;
          // After the final read the address stays on the last entry.
          if (!issue_last) begin
            addr_q <= sweep_addr(next_idx, transpose_q);
          end
        end
      end
    end
  end

  // Read-latency alignment: the valid/last tag of each issued read travels
  // alongside the register access and arrives together with its data.
  if (RD_LAT == 0) begin : g_no_lat
    assign push      = issue;
    assign push_last = issue_last;
    assign inflight  = 1'b0;
  end else begin : g_lat
    logic pipe_valid_q;
    logic pipe_last_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        pipe_valid_q <= 1'b0;
        pipe_last_q  <= 1'b0;
      end else if (clear_i) begin
        pipe_valid_q <= 1'b0;
        pipe_last_q  <= 1'b0;
      end else begin
        pipe_valid_q <= issue;
        pipe_last_q  <= issue && issue_last;
      end
    end

    assign push      = pipe_valid_q && !clear_i;
    assign push_last = pipe_last_q;
    assign inflight  = pipe_valid_q;
  end

  operand_skid_fifo #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (clear_i),
    .push_i      (push),
    .push_data_i ({push_last, read_data_Mat_i}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  assign addr_Mat_o     = addr_q;
  assign write_en_Mat_o = 1'b0;
  assign data_o         = fifo_head[DATA_WIDTH-1:0];
  assign valid_o        = (fifo_count != 2'd0);
  assign last_o         = valid_o && fifo_head[DATA_WIDTH];
  assign busy_o         = (state_q == RUN);
  assign done_o         = done_q;

endmodule

// File: tb/tb_operand_reg_reader.sv
// tb/tb_operand_reg_reader.sv - self-checking bench for operand_reg_reader
module tb_operand_reg_reader;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int MS = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic transpose = 1'b0;
  logic clear = 1'b0;
  logic ready = 1'b1;
  logic sel = 1'b0;

  logic start0, start1;
  logic [AW-1:0] addr0, addr1;
  logic we0, we1;
  logic [DW-1:0] rdata0, rdata1, data0, data1;
  logic valid0, valid1, last0, last1, busy0, busy1, done0, done1;

  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_data;
  logic cur_valid, cur_last, cur_busy, cur_done, cur_we;

  int n_asserts = 0;
  int n_fail = 0;
  int hs_cnt = 0;
  logic [DW:0] exp_q[$];

  always #5 clk = ~clk;

  assign start0 = start && !sel;
  assign start1 = start && sel;

  operand_reg_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MATRIX_SIZE(MS), .RD_LAT(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .transpose_i(transpose), .clear_i(clear),
    .addr_Mat_o(addr0), .write_en_Mat_o(we0), .read_data_Mat_i(rdata0),
    .data_o(data0), .valid_o(valid0), .ready_i(ready), .last_o(last0),
    .busy_o(busy0), .done_o(done0));

  operand_reg_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MATRIX_SIZE(MS), .RD_LAT(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .transpose_i(transpose), .clear_i(clear),
    .addr_Mat_o(addr1), .write_en_Mat_o(we1), .read_data_Mat_i(rdata1),
    .data_o(data1), .valid_o(valid1), .ready_i(ready), .last_o(last1),
    .busy_o(busy1), .done_o(done1));

  // Operand register models preloaded with value = 10 * addr.
  assign rdata0 = 32'd10 * {{(DW-AW){1'b0}}, addr0};
  always @(posedge clk) rdata1 <= 32'd10 * {{(DW-AW){1'b0}}, addr1};

  assign cur_addr  = sel ? addr1  : addr0;
  assign cur_data  = sel ? data1  : data0;
  assign cur_valid = sel ? valid1 : valid0;
  assign cur_last  = sel ? last1  : last0;
  assign cur_busy  = sel ? busy1  : busy0;
  assign cur_done  = sel ? done1  : done0;
  assign cur_we    = sel ? we1    : we0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW:0] exp_elem(input int i, input logic tr);
    int a;
    logic [DW-1:0] v;
    a = tr ? ((i % 4) * 4 + i / 4) : i;
    v = DW'(10 * a);
    return {(i == MS - 1), v};
  endfunction

  // Scoreboard consumer: compares each handshaken element and checks that
  // stalled outputs hold still.
  logic stall_q = 1'b0;
  logic [DW:0] held;
  logic [DW:0] exp_e;
  always @(negedge clk) begin
    if (stall_q && rst_n && !clear) begin
      check("hold_valid", cur_valid, 1'b1);
      check("hold_data", {cur_last, cur_data}, held);
    end
    stall_q = 1'b0;
    if (rst_n && !clear && cur_valid) begin
      if (ready) begin
        hs_cnt++;
        check("elem_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          exp_e = exp_q.pop_front();
          check("stream_elem", {cur_last, cur_data}, exp_e);
        end
      end else begin
        stall_q = 1'b1;
        held = {cur_last, cur_data};
      end
    end
  end

  task automatic start_sweep(input logic tr);
    start = 1'b1;
    transpose = tr;
    for (int i = 0; i < MS; i++) exp_q.push_back(exp_elem(i, tr));
    @(posedge clk); #1;
    start = 1'b0;
    transpose = ~tr;
    check("busy_after_start", cur_busy, 1'b1);
    check("addr_first", cur_addr, '0);
    check("done_low_at_start", cur_done, 1'b0);
  endtask

  task automatic run_until_done(input int max, input logic toggle, output int cyc, output int first_valid);
    cyc = -1;
    first_valid = -1;
    for (int k = 1; k <= max; k++) begin
      @(posedge clk); #1;
      if (first_valid < 0 && cur_valid) first_valid = k;
      if (toggle) ready = ((k % 4) == 0) || ((k % 4) == 3);
      if (cur_done) begin
        cyc = k;
        break;
      end
    end
    check("done_seen", cyc > 0, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, cur_addr, '0);
    check({tag, "_we"}, cur_we, 1'b0);
    check({tag, "_data"}, cur_data, '0);
    check({tag, "_valid"}, cur_valid, 1'b0);
    check({tag, "_last"}, cur_last, 1'b0);
    check({tag, "_busy"}, cur_busy, 1'b0);
    check({tag, "_done"}, cur_done, 1'b0);
  endtask

  initial begin
    int cyc, fv, lat;
    logic saw_done;

    repeat (3) @(posedge clk);
    #1;
    sel = 1'b0; #1; check_reset_outputs("reset0");
    sel = 1'b1; #1; check_reset_outputs("reset1");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      lat = s;
      ready = 1'b1;
      #1;

      // Row-major sweep with ready held high.
      start_sweep(1'b0);
      run_until_done(60, 1'b0, cyc, fv);
      check("rm_first_valid", fv, 2 + lat);
      check("rm_sweep_cycles", cyc, MS + 2 + lat);
      check("rm_busy_at_done", cur_busy, 1'b0);
      check("rm_queue_empty", exp_q.size(), 0);
      @(posedge clk); #1;
      check("rm_done_one_cycle", cur_done, 1'b0);

      // Backpressure with ready toggling.
      start_sweep(1'b0);
      run_until_done(200, 1'b1, cyc, fv);
      ready = 1'b1;
      check("bp_queue_empty", exp_q.size(), 0);
      check("bp_write_en", cur_we, 1'b0);

      // Transposed sweep, ignored start while busy, restart in done cycle.
      start_sweep(1'b1);
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1;
      transpose = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      check("tr_busy_kept", cur_busy, 1'b1);
      run_until_done(60, 1'b0, cyc, fv);
      check("tr_queue_empty", exp_q.size(), 0);
      start_sweep(1'b0);
      run_until_done(60, 1'b0, cyc, fv);
      check("restart_sweep_cycles", cyc, MS + 2 + lat);
      check("restart_queue_empty", exp_q.size(), 0);
      @(posedge clk); #1;

      // Clear after the 5th handshake.
      hs_cnt = 0;
      start_sweep(1'b0);
      for (int k = 0; k < 60; k++) begin
        if (hs_cnt >= 5) break;
        @(posedge clk); #1;
      end
      check("clr_reached_5", hs_cnt >= 5, 1'b1);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      exp_q.delete();
      check("clr_valid", cur_valid, 1'b0);
      check("clr_busy", cur_busy, 1'b0);
      check("clr_last", cur_last, 1'b0);
      saw_done = cur_done;
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); #1;
        saw_done = saw_done | cur_done;
      end
      check("clr_no_done", saw_done, 1'b0);
      start_sweep(1'b0);
      run_until_done(60, 1'b0, cyc, fv);
      check("clr_restart_cycles", cyc, MS + 2 + lat);
      check("clr_restart_queue_empty", exp_q.size(), 0);
      @(posedge clk); #1;

      // Asynchronous reset mid-sweep.
      start_sweep(1'b1);
      repeat (6) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs(s == 0 ? "areset0" : "areset1");
      exp_q.delete();
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
